// File: rtl/alpha_cpu_pkg.sv
// Shared constants and types for the alpha CPU front end.
package alpha_cpu_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam int          INST_W       = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/inst_hold_buf.sv
// One-entry buffer presenting a fetched instruction and its PC to decode.
module inst_hold_buf
   import alpha_cpu_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic              clr,
   input  logic [INST_W-1:0] inst_in,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] pc
);

   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      if (load) begin
         valid_d = 1'b1;
         inst_d  = inst_in;
         pc_d    = pc_in;
      end else if (clr) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= RESET_PC;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   assign valid = valid_q;
   assign inst  = inst_q;
   assign pc    = pc_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs one imem request at a time, applies redirects.
//
// state   | meaning
// IDLE    | just out of reset, no request yet
// REQ     | inst_req high with fetch_pc, waiting for addr_ok
// WAIT    | request accepted, waiting for data_ok (cancel_q drops stale data)
// HOLD    | instruction presented to decode until consumed or redirected
module pc_fetch_ctrl
   import alpha_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              W_redirect_valid,
   input  logic [ADDR_W-1:0] W_redirect_pc,
   input  logic              W_id_stall,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [INST_W-1:0] inst_rdata,
   output logic              W_inst_valid,
   output logic [INST_W-1:0] W_inst,
   output logic [ADDR_W-1:0] W_pc
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
   logic              cancel_q, cancel_d;
   logic              buf_load, buf_clr;
   logic [ADDR_W-1:0] redir_pc, next_seq_pc;
   logic              redir_lsb_unused;

   // targets are word aligned; the low two bits of the request are dropped
   assign redir_pc         = {W_redirect_pc[ADDR_W-1:2], 2'b00};
   assign redir_lsb_unused = ^W_redirect_pc[1:0];
   assign next_seq_pc      = issued_pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      issued_pc_d = issued_pc_q;
      cancel_d    = cancel_q;
      buf_load    = 1'b0;
      buf_clr     = 1'b0;
      case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (W_redirect_valid) fetch_pc_d = redir_pc;
            if (inst_addr_ok) begin
               issued_pc_d = fetch_pc_q;
               state_d     = ST_WAIT;
               if (W_redirect_valid) cancel_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (W_redirect_valid) begin
               cancel_d   = 1'b1;
               fetch_pc_d = redir_pc;
            end
            if (inst_data_ok) begin
               if (cancel_q || W_redirect_valid) begin
                  cancel_d = 1'b0;
                  state_d  = ST_REQ;
               end else begin
                  buf_load   = 1'b1;
                  fetch_pc_d = next_seq_pc;
                  state_d    = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (W_redirect_valid) begin
               buf_clr    = 1'b1;
               fetch_pc_d = redir_pc;
               state_d    = ST_REQ;
            end else if (!W_id_stall) begin
               buf_clr = 1'b1;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_PC[ADDR_W-1:0];
         issued_pc_q <= RESET_PC[ADDR_W-1:0];
         cancel_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         issued_pc_q <= issued_pc_d;
         cancel_q    <= cancel_d;
      end
   end

   assign inst_req  = (state_q == ST_REQ);
   assign inst_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};

   inst_hold_buf #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC[ADDR_W-1:0])
   ) u_hold_buf (
      .clk     (clk),
      .resetn  (resetn),
      .load    (buf_load),
      .clr     (buf_clr),
      .inst_in (inst_rdata),
      .pc_in   (issued_pc_q),
      .valid   (W_inst_valid),
      .inst    (W_inst),
      .pc      (W_pc)
   );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios followed by a randomized run.
module tb_pc_fetch_ctrl;
   import alpha_cpu_pkg::*;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        W_redirect_valid;
   logic [31:0] W_redirect_pc;
   logic        W_id_stall;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        W_inst_valid;
   logic [31:0] W_inst;
   logic [31:0] W_pc;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .W_redirect_valid (W_redirect_valid),
      .W_redirect_pc    (W_redirect_pc),
      .W_id_stall       (W_id_stall),
      .inst_req         (inst_req),
      .inst_addr        (inst_addr),
      .inst_addr_ok     (inst_addr_ok),
      .inst_data_ok     (inst_data_ok),
      .inst_rdata       (inst_rdata),
      .W_inst_valid     (W_inst_valid),
      .W_inst           (W_inst),
      .W_pc             (W_pc)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int consumed = 0;
   int rst_age  = 0;

   // expected PC of the next instruction decode will see
   logic [31:0] exp_q[$];
   logic [31:0] acc_q[$];

   bit          pending = 1'b0;
   logic [31:0] pend_addr;
   int          cd;

   int   ok_pct, stall_pct, redir_pct, lat_max;
   logic force_ok_en = 1'b0, force_ok_val = 1'b0;
   logic force_dok = 1'b0, force_redir = 1'b0;
   logic force_stall_en = 1'b0, force_stall_val = 1'b0;
   logic [31:0] force_tgt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s actual=timeout expected=event", name);
   endtask

   // drive one cycle of inputs, then advance to just after the next rising edge
   task automatic step();
      logic        ok;
      logic [31:0] t;
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (pending) begin
         if (cd <= 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(pend_addr);
            pending      = 1'b0;
         end else cd--;
      end else if (force_dok || $urandom_range(7) == 0) begin
         inst_data_ok = 1'b1;
      end
      inst_addr_ok = 1'b0;
      if (inst_req) begin
         ok = force_ok_en ? force_ok_val : ($urandom_range(99) < ok_pct);
         if (ok) begin
            inst_addr_ok = 1'b1;
            if (resetn) begin
               pending   = 1'b1;
               pend_addr = inst_addr;
               cd        = $urandom_range(lat_max);
               acc_q.push_back(inst_addr);
            end
         end
      end
      W_redirect_valid = 1'b0;
      W_redirect_pc    = $urandom;
      if (resetn && rst_age >= 2 && (force_redir || $urandom_range(99) < redir_pct)) begin
         t = $urandom;
         if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | {28'd0, t[3:0]};
         if (force_redir) t = force_tgt;
         W_redirect_valid = 1'b1;
         W_redirect_pc    = t;
         exp_q.delete();
         exp_q.push_back({t[31:2], 2'b00});
      end
      W_id_stall = force_stall_en ? force_stall_val : ($urandom_range(99) < stall_pct);
      if (!resetn) begin
         exp_q.delete();
         exp_q.push_back(RST_PC);
         pending = 1'b0;
      end
      @(posedge clk);
      #1;
      rst_age = resetn ? rst_age + 1 : 0;
   endtask

   logic        act, prev_act = 1'b0, prev_req, prev_ok, prev_redir;
   logic [31:0] prev_addr, e;

   always @(negedge clk) begin
      act = resetn && (rst_age >= 1);
      if (act) begin
         check32("addr_align", {30'd0, inst_addr[1:0]}, 32'd0);
         if (W_inst_valid) check32("req_while_hold", 32'(inst_req), 32'd0);
         if (prev_act && prev_req && !prev_ok && !prev_redir) begin
            check32("req_held", 32'(inst_req), 32'd1);
            check32("addr_stable", inst_addr, prev_addr);
         end
         if (W_inst_valid && !W_redirect_valid) begin
            if (exp_q.size() == 0) fail_now("exp_empty");
            else begin
               check32("w_pc", W_pc, exp_q[0]);
               check32("w_inst", W_inst, mem_word(exp_q[0]));
               if (!W_id_stall) begin
                  e = exp_q.pop_front();
                  exp_q.push_back(e + 32'd4);
                  consumed++;
               end
            end
         end
      end
      prev_act   = act;
      prev_req   = inst_req;
      prev_ok    = inst_addr_ok;
      prev_redir = W_redirect_valid;
      prev_addr  = inst_addr;
   end

   task automatic wait_req(input string name);
      for (int i = 0; i < 40 && !inst_req; i++) step();
      if (!inst_req) fail_now(name);
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 40 && !W_inst_valid; i++) step();
      if (!W_inst_valid) fail_now(name);
   endtask

   initial begin
      int c0;
      resetn = 1'b0;
      W_redirect_valid = 1'b0; W_redirect_pc = '0; W_id_stall = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
      ok_pct = 100; stall_pct = 0; redir_pct = 0; lat_max = 0;
      force_tgt = '0;
      @(posedge clk); #1;
      step(); step();
      check32("rst_req", 32'(inst_req), 32'd0);
      check32("rst_addr", inst_addr, RST_PC);
      check32("rst_valid", 32'(W_inst_valid), 32'd0);
      check32("rst_inst", W_inst, 32'd0);
      check32("rst_pc", W_pc, RST_PC);

      // release: IDLE for one cycle, then the first request at the reset PC
      resetn = 1'b1;
      step();
      check32("first_req", 32'(inst_req), 32'd1);
      check32("first_addr", inst_addr, RST_PC);

      for (int i = 0; i < 40 && !(W_inst_valid && W_pc == RST_PC + 32'd4); i++) step();
      if (!(W_inst_valid && W_pc == RST_PC + 32'd4)) fail_now("wait_hold4");
      force_stall_en = 1'b1; force_stall_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check32("stall_valid", 32'(W_inst_valid), 32'd1);
         check32("stall_pc", W_pc, RST_PC + 32'd4);
         check32("stall_inst", W_inst, mem_word(RST_PC + 32'd4));
      end
      force_stall_en = 1'b0;
      wait_req("wait_req8");
      check32("after_stall_addr", inst_addr, RST_PC + 32'd8);

      // redirect while the fetch of +8 is outstanding
      step();
      cd = 2;
      force_redir = 1'b1; force_tgt = 32'h8000_0101;
      step();
      force_redir = 1'b0;
      if (acc_q.size() >= 3) begin
         check32("acc0", acc_q[0], RST_PC);
         check32("acc1", acc_q[1], RST_PC + 32'd4);
         check32("acc2", acc_q[2], RST_PC + 32'd8);
      end else fail_now("acc_count");
      for (int i = 0; i < 40 && !inst_req; i++) begin
         check32("wait_redir_novalid", 32'(W_inst_valid), 32'd0);
         step();
      end
      check32("wait_redir_addr", inst_addr, 32'h8000_0100);
      wait_valid("wait_redir_deliver");
      check32("wait_redir_pc", W_pc, 32'h8000_0100);

      // redirect with addr_ok, then a second redirect while REQ is stalled
      wait_req("wait_req_b");
      force_ok_en = 1'b1; force_ok_val = 1'b1;
      force_redir = 1'b1; force_tgt = 32'h8000_0200;
      step();
      force_redir = 1'b0; force_ok_val = 1'b0;
      wait_req("wait_req_c");
      check32("redir_ok_addr", inst_addr, 32'h8000_0200);
      force_redir = 1'b1; force_tgt = 32'h8000_0300;
      step();
      force_redir = 1'b0;
      step();
      check32("redir_req_addr", inst_addr, 32'h8000_0300);
      force_ok_en = 1'b0;
      wait_valid("wait_deliver_300");
      check32("redir_req_pc", W_pc, 32'h8000_0300);

      // wrap of the fetch PC past the top of the address space
      force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
      step();
      force_redir = 1'b0;
      for (int i = 0; i < 40 && !(W_inst_valid && W_pc == 32'hFFFF_FFFC); i++) step();
      if (!(W_inst_valid && W_pc == 32'hFFFF_FFFC)) fail_now("wait_wrap");
      wait_req("wait_req_wrap");
      check32("wrap_addr", inst_addr, 32'h0000_0000);

      // reset during WAIT with responses in the reset cycle and the IDLE cycle
      force_ok_en = 1'b1; force_ok_val = 1'b1;
      step();
      force_ok_en = 1'b0;
      cd = 0;
      resetn = 1'b0;
      step();
      check32("rst_wait_valid", 32'(W_inst_valid), 32'd0);
      check32("rst_wait_req", 32'(inst_req), 32'd0);
      resetn = 1'b1;
      force_dok = 1'b1;
      step();
      force_dok = 1'b0;
      check32("rst_idle_valid", 32'(W_inst_valid), 32'd0);
      check32("rst_restart_req", 32'(inst_req), 32'd1);
      check32("rst_restart_addr", inst_addr, RST_PC);
      wait_valid("wait_rst_deliver");
      check32("rst_restart_pc", W_pc, RST_PC);

      // randomized traffic, occasional resets
      ok_pct = 60; stall_pct = 30; redir_pct = 5; lat_max = 3;
      c0 = consumed;
      for (int i = 0; i < 4000; i++) begin
         resetn = ($urandom_range(599) != 0);
         step();
      end
      resetn = 1'b1;
      step();
      check32("random_progress", 32'(consumed - c0 >= 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
